fft_out_serializer: RTL
=======================

// Module: fft_out_serializer
// PURPOSE
//  Sink for the 64-point in-place FFT output stream. Captures one burst of N/2 dual-lane
//  beats (lane0/lane1 = samples 2k/2k+1) into a local buffer, then replays the N samples
//  one per cycle over a valid/ready interface to downstream logic (magnitude, file dump).
//  It is the receiving end of the FFT core's 2-samples/cycle output port.
// PARAMETERS
//  N   64  transform length in samples; power of two, >= 4
//  W   16  sample width, two's complement, per real/imag part
//  AW  6   log2(N); sample address width
// PORTS
//  clk       in   1   rising-edge clock
//  nrst      in   1   asynchronous reset, active-high (1 = reset asserted)
//  in_valid  in   1   FFT output beat valid
//  in_re0    in   W   lane0 real (sample 2k)
//  in_im0    in   W   lane0 imag
//  in_re1    in   W   lane1 real (sample 2k+1)
//  in_im1    in   W   lane1 imag
//  out_valid out  1   serial sample valid
//  out_ready in   1   downstream accepts sample
//  out_re    out  W   serial sample real
//  out_im    out  W   serial sample imag
//  out_idx   out  AW  frequency index of current sample
//  out_last  out  1   high with sample index N-1
//  busy      out  1   high in FILL or DRAIN
//  overflow  out  1   sticky: beat arrived while DRAIN; cleared only by reset
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, fill/drain counters=0, out_valid=0, out_last=0,
//    out_re=out_im=0, out_idx=0, busy=0, overflow=0. Buffer contents not reset.
//  - States: IDLE -> FILL on in_valid; FILL -> DRAIN after beat N/2-1 written;
//    DRAIN -> IDLE on handshake (out_valid&out_ready) with out_last=1.
//  - IDLE beat is written immediately (addr 0/1), fill counter -> 1, state FILL.
//  - FILL: each in_valid beat k writes lane0 to addr 2k, lane1 to 2k+1; gaps in in_valid
//    hold counter. No backpressure toward FFT; every FILL/IDLE beat is taken.
//  - Latency: out_valid rises the cycle after the last beat's clock edge.
//  - DRAIN: out_valid=1; out_re/out_im read combinationally from buffer at drain addr;
//    counter advances only on handshake; data/idx stable while out_ready=0.
//  - out_re/out_im = 0 whenever out_valid=0. Data passed bit-exact, no arithmetic.
//  - in_valid during DRAIN: beat dropped, buffer untouched, overflow set.
//  - in_valid on the same cycle as final handshake: still DRAIN -> dropped, overflow set.
//  - Counters wrap at N/2 (fill) and N (drain) and are re-zeroed on state exit.
//  - Reset mid-FILL/DRAIN: partial burst discarded; next burst starts at addr 0.
// CONFIGURATION
//  BITREV_EN defined: drain read address = bit-reverse(drain counter, AW bits); out_idx =
//    counter, so natural-order output from a bit-reversed-order core.
//  BITREV_EN undefined: read address = drain counter (natural order pass-through).
// STRUCTURE
//  - Package fft_pkg: N, W, AW localparams; state encodings IDLE/FILL/DRAIN;
//    function bitrev(AW) shared with FFT core address generator.
//  - Sub-module fft_sample_buf: N x 2W register file, two write ports (even/odd addr,
//    one enable), one combinational read port. Controller FSM + counters in top.
// TESTING
//  1 Reset: nrst=1 any time -> all outputs 0 same cycle; release -> IDLE, busy=0.
//  2 Ramp: 32 back-to-back beats re0=2k,re1=2k+1, im=-re; out_ready=1 -> 64 samples
//    idx 0..63, out_re=idx, out_im=-idx, out_last only at 63, then busy=0.
//  3 Backpressure+gaps: in_valid every other cycle; out_ready pattern 1,0,0,1 -> same
//    64 samples in order, values stable while ready=0, none lost or duplicated.
//  4 Overflow: new in_valid at drain idx 5 -> overflow=1, drained data unchanged,
//    overflow still 1 after DRAIN ends; reset clears it.
//  5 Reset mid-DRAIN at idx 10, then fresh ramp burst -> drain restarts cleanly at idx 0.
//  6 BITREV_EN build, ramp input -> idx1 out_re=32, idx2 out_re=16, idx63 out_re=63.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path.
//   N, W, AW : transform length, sample width, sample address width
//   state_e  : serializer controller states
//   bitrev   : AW-bit address bit reversal (also used by the FFT core address generator)
package fft_pkg;

  localparam int unsigned N  = 64;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_buf.sv
// Sample buffer for the FFT output serializer.
// N x 2W register file, no reset (contents are don't-care until written).
//   clk                      : rising-edge clock
//   we                       : write enable for both lanes
//   wr_pair                  : beat index k; lane0 -> addr 2k, lane1 -> addr 2k+1
//   wr_re0/wr_im0            : lane0 sample
//   wr_re1/wr_im1            : lane1 sample
//   rd_addr                  : combinational read address
//   rd_re/rd_im              : sample at rd_addr
module fft_sample_buf
  import fft_pkg::*;
#(
  parameter int unsigned N  = fft_pkg::N,
  parameter int unsigned W  = fft_pkg::W,
  parameter int unsigned AW = fft_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-2:0] wr_pair,
  input  logic [W-1:0]  wr_re0,
  input  logic [W-1:0]  wr_im0,
  input  logic [W-1:0]  wr_re1,
  input  logic [W-1:0]  wr_im1,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_re,
  output logic [W-1:0]  rd_im
);

  logic [W-1:0] mem_re [N];
  logic [W-1:0] mem_im [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[{wr_pair, 1'b0}] <= wr_re0;
      mem_im[{wr_pair, 1'b0}] <= wr_im0;
      mem_re[{wr_pair, 1'b1}] <= wr_re1;
      mem_im[{wr_pair, 1'b1}] <= wr_im1;
    end
  end

  always_comb begin
    rd_re = mem_re[rd_addr];
    rd_im = mem_im[rd_addr];
  end

endmodule

// File: rtl/fft_out_serializer.sv
// FFT output serializer: captures one burst of N/2 dual-lane beats from the FFT core
// and replays the N samples one per cycle over valid/ready.
//   clk, nrst                : clock, asynchronous active-high reset
//   in_valid, in_re0/im0,
//   in_re1/im1               : FFT beat (samples 2k and 2k+1), no backpressure
//   out_valid, out_ready     : serial handshake
//   out_re, out_im, out_idx  : serial sample and its frequency index
//   out_last                 : marks index N-1
//   busy                     : capturing or replaying a burst
//   overflow                 : sticky, a beat arrived while replaying
// Build option: BITREV_EN reads the buffer at bitrev(drain counter) so a
// bit-reversed-order core produces natural-order output.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned N  = fft_pkg::N,
  parameter int unsigned W  = fft_pkg::W,
  parameter int unsigned AW = fft_pkg::AW
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_re0,
  input  logic [W-1:0]  in_im0,
  input  logic [W-1:0]  in_re1,
  input  logic [W-1:0]  in_im1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_re,
  output logic [W-1:0]  out_im,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);

  localparam logic [AW-2:0] FILL_LAST  = '1;
  localparam logic [AW-1:0] DRAIN_LAST = '1;

  state_e        state_q,     state_d;
  logic [AW-2:0] fill_cnt_q,  fill_cnt_d;
  logic [AW-1:0] drain_cnt_q, drain_cnt_d;
  logic          overflow_q,  overflow_d;

  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_re;
  logic [W-1:0]  rd_im;

  // Every beat outside DRAIN is taken; in IDLE the fill counter is zero so the
  // first beat lands at addresses 0/1.
  assign wr_en = in_valid && (state_q != DRAIN);

  always_comb begin
`ifdef BITREV_EN
    rd_addr = bitrev(drain_cnt_q);
`else
    rd_addr = drain_cnt_q;
`endif
  end

  fft_sample_buf #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) u_buf (
    .clk     (clk),
    .we      (wr_en),
    .wr_pair (fill_cnt_q),
    .wr_re0  (in_re0),
    .wr_im0  (in_im0),
    .wr_re1  (in_re1),
    .wr_im1  (in_im1),
    .rd_addr (rd_addr),
    .rd_re   (rd_re),
    .rd_im   (rd_im)
  );

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          fill_cnt_d = (AW-1)'(1);
          state_d    = FILL;
        end
      end
      FILL: begin
        if (in_valid) begin
          if (fill_cnt_q == FILL_LAST) begin
            fill_cnt_d = '0;
            state_d    = DRAIN;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // out_valid is 1 throughout DRAIN, so out_ready alone is the handshake.
        if (in_valid) begin
          overflow_d = 1'b1;
        end
        if (out_ready) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            drain_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        fill_cnt_d  = '0;
        drain_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_q == DRAIN);
    out_last  = out_valid && (drain_cnt_q == DRAIN_LAST);
    out_idx   = drain_cnt_q;
    out_re    = out_valid ? rd_re : '0;
    out_im    = out_valid ? rd_im : '0;
    busy      = (state_q != IDLE);
    overflow  = overflow_q;
  end

endmodule
